// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - instruction/data memory request handshake
interface mc_control_unit_if;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RV32I controller, instruction register and decoder
module mc_control_unit (
    input  logic                     clk,
    input  logic                     reset,
    mc_control_unit_if.master        mem,
    input  logic                     alu_zero,
    output logic                     pc_write,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [31:0]              imm,
    output logic [1:0]               MtoR,
    output logic                     RegWrite,
    output logic                     AluSrcA,
    output logic [1:0]               AluSrcB,
    output logic [3:0]               alu_ctrl,
    output logic                     halted
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_AUIPC,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_WB_LUI,
        S_BR_CMP,
        S_BR_TAKE,
        S_PC_INC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic        ir_load;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rd_nz;
    logic        r_legal;

    logic        req_c;
    logic        we_c;
    logic        asel_c;
    logic        pcw_c;
    logic        rw_c;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];
    assign rd_nz  = (rd != 5'd0);

    // The alternate encoding (SUB/SRA) exists only for funct3 000 and 101.
    assign r_legal = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= 32'd0;
        end else begin
            state <= state_nx;
            if (ir_load) begin
                ir <= mem.mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ir_load  = 1'b0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        asel_c   = 1'b0;
        pcw_c    = 1'b0;
        rw_c     = 1'b0;
        MtoR     = 2'b00;
        AluSrcA  = 1'b0;
        AluSrcB  = 2'b00;
        alu_ctrl = ALU_ADD;

        case (state)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_load  = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_nx = S_EXEC_R;
                    OP_I:               state_nx = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_nx = S_ADDR;
                    OP_LUI:             state_nx = S_WB_LUI;
                    OP_AUIPC:           state_nx = S_EXEC_AUIPC;
                    OP_BR:              state_nx = S_BR_CMP;
                    default:            state_nx = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                AluSrcA  = 1'b1;
                alu_ctrl = alu_op(funct3, funct7[5]);
                state_nx = r_legal ? S_WB_ALU : S_TRAP;
            end
            S_EXEC_I: begin
                AluSrcA  = 1'b1;
                AluSrcB  = 2'b10;
                alu_ctrl = alu_op(funct3, (funct3 == 3'b101) && ir[30]);
                state_nx = S_WB_ALU;
            end
            S_EXEC_AUIPC: begin
                AluSrcB  = 2'b10;
                state_nx = S_WB_ALU;
            end
            S_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
                if (funct3 != 3'b010) begin
                    state_nx = S_TRAP;
                end else if (opcode == OP_LOAD) begin
                    state_nx = S_MEM_RD;
                end else begin
                    state_nx = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                req_c  = 1'b1;
                asel_c = 1'b1;
                if (mem.mem_ready) begin
                    state_nx = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                req_c  = 1'b1;
                we_c   = 1'b1;
                asel_c = 1'b1;
                if (mem.mem_ready) begin
                    state_nx = S_PC_INC;
                end
            end
            S_WB_ALU: begin
                rw_c     = rd_nz;
                state_nx = S_PC_INC;
            end
            S_WB_MEM: begin
                MtoR     = 2'b01;
                rw_c     = rd_nz;
                state_nx = S_PC_INC;
            end
            S_WB_LUI: begin
                MtoR     = 2'b10;
                rw_c     = rd_nz;
                state_nx = S_PC_INC;
            end
            S_BR_CMP: begin
                AluSrcA  = 1'b1;
                alu_ctrl = ALU_SUB;
                case (funct3)
                    3'b000:  state_nx = alu_zero  ? S_BR_TAKE : S_PC_INC;
                    3'b001:  state_nx = !alu_zero ? S_BR_TAKE : S_PC_INC;
                    default: state_nx = S_TRAP;
                endcase
            end
            S_BR_TAKE: begin
                AluSrcB  = 2'b10;
                pcw_c    = 1'b1;
                state_nx = S_FETCH;
            end
            S_PC_INC: begin
                AluSrcB  = 2'b01;
                pcw_c    = 1'b1;
                state_nx = S_FETCH;
            end
            default: begin
                state_nx = S_TRAP;
            end
        endcase
    end

    // Strobes are gated by reset directly so an abandoned request drops without waiting for a clock.
    assign mem.mem_req  = req_c & ~reset;
    assign mem.mem_we   = we_c & ~reset;
    assign mem.addr_sel = asel_c;
    assign pc_write     = pcw_c & ~reset;
    assign RegWrite     = rw_c & ~reset;
    assign halted       = (state == S_TRAP);

    always_comb begin
        imm = 32'd0;
        case (opcode)
            OP_I, OP_LOAD:     imm = {{20{ir[31]}}, ir[31:20]};
            OP_STORE:          imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BR:             imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_LUI, OP_AUIPC:  imm = {ir[31:12], 12'd0};
            default:           imm = 32'd0;
        endcase
    end

endmodule
